// File: rtl/packet_tag_engine.sv
// Responder for the packetstorage out/tag interface: consumes released packets and returns one
// {port, channel} forwarding tag per packet after a fixed delay, bounding in-flight tags by credit.
module packet_tag_engine #(
    parameter int unsigned LATENCY      = 7,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned HDR_WORD     = 0,
    parameter int unsigned PORT_LSB     = 0,
    parameter logic [1:0]  DEFAULT_PORT = 2'b11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] outstream_data,
    input  logic        outstream_valid,
    input  logic        outstream_sop,
    input  logic        outstream_eop,
    input  logic [5:0]  outstream_channel,
    output logic        outstream_ready,
    output logic [7:0]  tagstream_data,
    output logic        tagstream_valid,
    input  logic        tagstream_ready,
    output logic [15:0] err_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OUT_W = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [5:0]  chan_q, chan_d;
    logic [1:0]  port_q, port_d;
    logic [15:0] err_d;
    logic        emit;
    logic [7:0]  emit_tag;
    logic        accept;
    logic [7:0]  cur_idx;
    logic        hdr_hit;
    logic [1:0]  beat_port;
    logic        data_unused;

    logic [LATENCY-1:0] pipe_v;
    logic [7:0]         pipe_tag [LATENCY];
    logic               push;
    logic [7:0]         push_tag;
    logic               pop;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       head_d;
    logic [OUT_W-1:0] pipe_cnt_d;
    logic [OUT_W-1:0] outstanding_d;
    logic             ready_d;
    logic             tvalid_d;
    logic [7:0]       tdata_d;

    assign accept      = outstream_valid & outstream_ready;
    assign beat_port   = outstream_data[PORT_LSB +: 2];
    assign data_unused = ^outstream_data;
    assign push        = pipe_v[LATENCY-1];
    assign push_tag    = pipe_tag[LATENCY-1];
    assign pop         = tagstream_valid & tagstream_ready;

    // Packet framing FSM: next state, header capture, tag emission and error counting.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        chan_d     = chan_q;
        port_d     = port_q;
        err_d      = err_count;
        emit       = 1'b0;
        emit_tag   = 8'h00;
        cur_idx    = 8'd0;
        if (state_q == ST_IN_PKT && !outstream_sop) begin
            cur_idx = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
        end
        hdr_hit = (cur_idx == 8'(HDR_WORD));

        if (accept) begin
            if (outstream_sop) begin
                // A sop inside an open packet abandons it; its credit passes to the new packet.
                if (state_q == ST_IN_PKT) begin
                    err_d = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
                end
                chan_d     = outstream_channel;
                beat_cnt_d = 8'd0;
                port_d     = hdr_hit ? beat_port : DEFAULT_PORT;
                if (outstream_eop) begin
                    emit     = 1'b1;
                    emit_tag = {port_d, outstream_channel};
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_IN_PKT;
                end
            end else if (state_q == ST_IN_PKT) begin
                beat_cnt_d = cur_idx;
                if (hdr_hit) begin
                    port_d = beat_port;
                end
                if (outstream_eop) begin
                    emit     = 1'b1;
                    emit_tag = {port_d, chan_q};
                    state_d  = ST_IDLE;
                end
            end else begin
                err_d = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
            end
        end
    end

    // FIFO bookkeeping and registered-output next values (credit and first-word-fall-through head).
    always_comb begin
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? push_tag : mem[rd_ptr_d];

        pipe_cnt_d = OUT_W'(emit);
        for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
            pipe_cnt_d = pipe_cnt_d + OUT_W'(pipe_v[i]);
        end
        outstanding_d = OUT_W'(count_d) + pipe_cnt_d + OUT_W'(state_d == ST_IN_PKT);
        ready_d = (outstanding_d < OUT_W'(FIFO_DEPTH)) |
                  ((state_d == ST_IN_PKT) & (outstanding_d <= OUT_W'(FIFO_DEPTH)));

        tvalid_d = (count_d != '0);
        tdata_d  = tvalid_d ? head_d : tagstream_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            beat_cnt_q      <= 8'd0;
            chan_q          <= 6'd0;
            port_q          <= DEFAULT_PORT;
            err_count       <= 16'd0;
            pipe_v          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            outstream_ready <= 1'b0;
            tagstream_valid <= 1'b0;
            tagstream_data  <= 8'h00;
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            chan_q          <= chan_d;
            port_q          <= port_d;
            err_count       <= err_d;
            pipe_v          <= (pipe_v << 1) | LATENCY'(emit);
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            outstream_ready <= ready_d;
            tagstream_valid <= tvalid_d;
            tagstream_data  <= tdata_d;
        end
    end

    // Tag payload storage; qualified by pipe_v and count_q so it needs no reset.
    always_ff @(posedge clock) begin
        pipe_tag[0] <= emit_tag;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
        if (push) begin
            mem[wr_ptr_q] <= push_tag;
        end
    end

endmodule

// File: tb/tb_packet_tag_engine.sv
// Directed bench for packet_tag_engine: default instance plus one with the header on beat 2.
module tb_packet_tag_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] outstream_data;
    logic        outstream_valid, outstream_sop, outstream_eop;
    logic [5:0]  outstream_channel;
    logic        outstream_ready;
    logic [7:0]  tagstream_data;
    logic        tagstream_valid, tagstream_ready;
    logic [15:0] err_count;

    logic [63:0] h_data;
    logic        h_valid, h_sop, h_eop;
    logic [5:0]  h_channel;
    logic        h_ready;
    logic [7:0]  h_tdata;
    logic        h_tvalid, h_tready;
    logic [15:0] h_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] tag_q[$];
    int         tag_cyc[$];

    always #5 clock = ~clock;

    packet_tag_engine dut (
        .clock(clock), .reset(reset),
        .outstream_data(outstream_data), .outstream_valid(outstream_valid),
        .outstream_sop(outstream_sop), .outstream_eop(outstream_eop),
        .outstream_channel(outstream_channel), .outstream_ready(outstream_ready),
        .tagstream_data(tagstream_data), .tagstream_valid(tagstream_valid),
        .tagstream_ready(tagstream_ready), .err_count(err_count)
    );

    packet_tag_engine #(.HDR_WORD(2)) dut_h2 (
        .clock(clock), .reset(reset),
        .outstream_data(h_data), .outstream_valid(h_valid),
        .outstream_sop(h_sop), .outstream_eop(h_eop),
        .outstream_channel(h_channel), .outstream_ready(h_ready),
        .tagstream_data(h_tdata), .tagstream_valid(h_tvalid),
        .tagstream_ready(h_tready), .err_count(h_err)
    );

    // Cycle counter and log of every tag handed off by the default instance.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset === 1'b0 && tagstream_valid === 1'b1 && tagstream_ready === 1'b1) begin
            tag_q.push_back(tagstream_data);
            tag_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        tag_q.delete();
        tag_cyc.delete();
    endtask

    task automatic send_beat(input logic sop, input logic eop, input logic [5:0] ch,
                             input logic [63:0] data, output int acc_cyc);
        int n = 0;
        outstream_valid   = 1'b1;
        outstream_sop     = sop;
        outstream_eop     = eop;
        outstream_channel = ch;
        outstream_data    = data;
        while (outstream_ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (outstream_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_beat_accept ready=%b required=1", outstream_ready);
        end
        acc_cyc = cyc;
        step();
        outstream_valid = 1'b0;
        outstream_sop   = 1'b0;
        outstream_eop   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        outstream_valid = 1'b0; outstream_sop = 1'b0; outstream_eop = 1'b0;
        outstream_channel = 6'd0; outstream_data = 64'd0; tagstream_ready = 1'b0;
        h_valid = 1'b0; h_sop = 1'b0; h_eop = 1'b0; h_channel = 6'd0; h_data = 64'd0;
        h_tready = 1'b1;
        repeat (3) step();
        checks++; if (outstream_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", outstream_ready); end
        checks++; if (tagstream_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", tagstream_valid); end
        checks++; if (tagstream_data !== 8'h00) begin errors++; $display("FAIL reset_tdata got=%h exp=00", tagstream_data); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        reset = 1'b0;
        step();
        checks++; if (outstream_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", outstream_ready); end
    endtask

    task automatic test_back_to_back();
        int eop_c[3];
        tagstream_ready = 1'b1;
        clear_log();
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                outstream_valid   = 1'b1;
                outstream_sop     = (b == 0);
                outstream_eop     = (b == 3);
                outstream_channel = 6'd5;
                outstream_data    = (b == 0) ? 64'h2 : '1;
                checks++;
                if (outstream_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready pkt=%0d beat=%0d got=%b exp=1", p, b, outstream_ready);
                end
                if (b == 3) eop_c[p] = cyc;
                step();
            end
        end
        outstream_valid = 1'b0; outstream_sop = 1'b0; outstream_eop = 1'b0;
        repeat (12) step();
        checks++;
        if (tag_q.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", tag_q.size()); end
        for (int p = 0; p < 3 && p < tag_q.size(); p++) begin
            checks++;
            if (tag_q[p] !== 8'h85) begin errors++; $display("FAIL b2b_tag pkt=%0d got=%h exp=85", p, tag_q[p]); end
            checks++;
            if (tag_cyc[p] != eop_c[p] + 8) begin
                errors++;
                $display("FAIL b2b_latency pkt=%0d got=%0d exp=%0d", p, tag_cyc[p] - eop_c[p], 8);
            end
        end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL b2b_err got=%0d exp=0", err_count); end
    endtask

    task automatic test_single_beat();
        int c;
        clear_log();
        send_beat(1'b1, 1'b1, 6'h3F, 64'hFFFF_FFFF_FFFF_FFFD, c);
        repeat (10) step();
        checks++;
        if (tag_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", tag_q.size()); end
        if (tag_q.size() > 0) begin
            checks++;
            if (tag_q[0] !== 8'h7F) begin errors++; $display("FAIL single_tag got=%h exp=7f", tag_q[0]); end
            checks++;
            if (tag_cyc[0] != c + 8) begin errors++; $display("FAIL single_latency got=%0d exp=8", tag_cyc[0] - c); end
        end
    endtask

    task automatic test_credit();
        int c;
        logic [7:0] exp_tag [6];
        exp_tag = '{8'h0A, 8'h4B, 8'h8C, 8'hCD, 8'h0E, 8'h4F};
        tagstream_ready = 1'b0;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            send_beat(1'b1, 1'b1, 6'(10 + i), 64'(i % 4), c);
        end
        outstream_valid = 1'b1; outstream_sop = 1'b1; outstream_eop = 1'b1;
        outstream_channel = 6'd14; outstream_data = 64'h4;
        repeat (12) step();
        checks++; if (outstream_ready !== 1'b0) begin errors++; $display("FAIL credit_full_ready got=%b exp=0", outstream_ready); end
        checks++; if (tagstream_valid !== 1'b1) begin errors++; $display("FAIL credit_tvalid got=%b exp=1", tagstream_valid); end
        checks++; if (tagstream_data !== 8'h0A) begin errors++; $display("FAIL credit_head got=%h exp=0a", tagstream_data); end
        checks++; if (tag_q.size() != 0) begin errors++; $display("FAIL credit_early_pop got=%0d exp=0", tag_q.size()); end
        tagstream_ready = 1'b1;
        send_beat(1'b1, 1'b1, 6'd14, 64'h4, c);
        send_beat(1'b1, 1'b1, 6'd15, 64'h5, c);
        repeat (14) step();
        checks++;
        if (tag_q.size() != 6) begin errors++; $display("FAIL credit_count got=%0d exp=6", tag_q.size()); end
        for (int i = 0; i < 6 && i < tag_q.size(); i++) begin
            checks++;
            if (tag_q[i] !== exp_tag[i]) begin errors++; $display("FAIL credit_order idx=%0d got=%h exp=%h", i, tag_q[i], exp_tag[i]); end
        end
        checks++; if (outstream_ready !== 1'b1) begin errors++; $display("FAIL credit_ready_return got=%b exp=1", outstream_ready); end
    endtask

    task automatic test_hdr_default();
        int c;
        int n;
        logic [63:0] beats [3];
        // Two-beat packet ends before beat 2: default port.
        h_valid = 1'b1; h_sop = 1'b1; h_eop = 1'b0; h_channel = 6'd1; h_data = 64'h2;
        checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL hdr_ready got=%b exp=1", h_ready); end
        step();
        h_sop = 1'b0; h_eop = 1'b1; h_data = 64'h1;
        c = cyc;
        step();
        h_valid = 1'b0; h_eop = 1'b0;
        n = 0;
        while (h_tvalid !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (h_tdata !== 8'hC1 || h_tvalid !== 1'b1) begin errors++; $display("FAIL hdr_default_tag got=%h v=%b exp=c1", h_tdata, h_tvalid); end
        checks++; if (cyc != c + 8) begin errors++; $display("FAIL hdr_default_latency got=%0d exp=8", cyc - c); end
        step();
        // Three-beat packet: port taken from beat 2 only.
        beats = '{64'h3, 64'h3, 64'h2};
        for (int b = 0; b < 3; b++) begin
            h_valid = 1'b1; h_sop = (b == 0); h_eop = (b == 2); h_channel = 6'd2; h_data = beats[b];
            step();
        end
        h_valid = 1'b0; h_sop = 1'b0; h_eop = 1'b0;
        n = 0;
        while (h_tvalid !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (h_tdata !== 8'h82 || h_tvalid !== 1'b1) begin errors++; $display("FAIL hdr_capture_tag got=%h v=%b exp=82", h_tdata, h_tvalid); end
        step();
        checks++; if (h_err !== 16'd0) begin errors++; $display("FAIL hdr_err got=%0d exp=0", h_err); end
    endtask

    task automatic test_abort();
        int c;
        clear_log();
        send_beat(1'b1, 1'b0, 6'd7, 64'h1, c);
        send_beat(1'b0, 1'b0, 6'd7, 64'h0, c);
        send_beat(1'b1, 1'b0, 6'd3, 64'h2, c);
        send_beat(1'b0, 1'b0, 6'd3, 64'h0, c);
        send_beat(1'b0, 1'b1, 6'd3, 64'h0, c);
        repeat (14) step();
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL abort_err got=%0d exp=1", err_count); end
        checks++; if (tag_q.size() != 1) begin errors++; $display("FAIL abort_count got=%0d exp=1", tag_q.size()); end
        if (tag_q.size() > 0) begin
            checks++;
            if (tag_q[0] !== 8'h83) begin errors++; $display("FAIL abort_tag got=%h exp=83", tag_q[0]); end
        end
    endtask

    task automatic test_orphan_reset();
        int c;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        clear_log();
        send_beat(1'b0, 1'b0, 6'd9, '1, c);
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL orphan_err got=%0d exp=1", err_count); end
        send_beat(1'b1, 1'b0, 6'd9, 64'h1, c);
        send_beat(1'b0, 1'b0, 6'd9, 64'h0, c);
        reset = 1'b1;
        step();
        checks++; if (outstream_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", outstream_ready); end
        checks++; if (tagstream_valid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got=%b exp=0", tagstream_valid); end
        checks++; if (tagstream_data !== 8'h00) begin errors++; $display("FAIL midrst_tdata got=%h exp=00", tagstream_data); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL midrst_err got=%0d exp=0", err_count); end
        step();
        reset = 1'b0;
        repeat (15) step();
        checks++; if (tag_q.size() != 0) begin errors++; $display("FAIL midrst_no_tag got=%0d exp=0", tag_q.size()); end
        // A lone eop after reset must be an orphan, proving the open packet was discarded.
        send_beat(1'b0, 1'b1, 6'd9, 64'h0, c);
        repeat (12) step();
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL post_rst_eop_err got=%0d exp=1", err_count); end
        checks++; if (tag_q.size() != 0) begin errors++; $display("FAIL post_rst_eop_tag got=%0d exp=0", tag_q.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_beat();
        test_credit();
        test_hdr_default();
        test_abort();
        test_orphan_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
